// File: rtl/digilock_code_ctrl.sv
// Digital lock code controller: programs / checks a 4-word code against an external memory.
// Optional lockout after repeated failed checks is enabled with `define DIGILOCK_LOCKOUT_EN.
module digilock_code_ctrl #(
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_prog,
    input  logic        cmd_check,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [1:0]  mem_idx,
    output logic        mem_wr,
    output logic        mem_enable,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        locked
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROG    = 3'd1;
    localparam logic [2:0] S_CHK_RD  = 3'd2;
    localparam logic [2:0] S_CHK_CMP = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    if (MAX_FAILS == 0 || LOCK_CYCLES == 0) begin : g_bad_params
        $error("digilock_code_ctrl: MAX_FAILS and LOCK_CYCLES must be at least 1");
    end

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] w_din_nxt;
    logic              r_match;
    logic              w_match_nxt;
    logic              r_busy;
    logic              r_done;
    logic              r_din_ready;
    logic              w_xfer;
    logic              w_word_bad;
    logic              w_cmd_ok;

    assign w_xfer     = din_valid & r_din_ready;
    assign w_word_bad = (mem_rdata != r_din);

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign match     = r_match;

    // Next-state, datapath and same-cycle memory strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_din_nxt   = r_din;
        w_match_nxt = r_match;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_idx     = '0;
        mem_wdata   = '0;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_ok && (cmd_prog || cmd_check)) begin
                    w_state_nxt = cmd_prog ? S_PROG : S_CHK_RD;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_match_nxt = 1'b0;
                end
            end
            S_PROG: begin
                if (w_xfer) begin
                    mem_enable = 1'b1;
                    mem_wr     = 1'b1;
                    mem_idx    = r_cnt;
                    mem_wdata  = din;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(3)) begin
                        w_state_nxt = S_FINISH;
                        w_match_nxt = 1'b0;
                    end
                end
            end
            S_CHK_RD: begin
                if (w_xfer) begin
                    mem_enable  = 1'b1;
                    mem_idx     = r_cnt;
                    w_din_nxt   = din;
                    w_state_nxt = S_CHK_CMP;
                end
            end
            S_CHK_CMP: begin
                // Every word is compared even after a mismatch so timing is data-independent
                if (w_word_bad) begin
                    w_err_nxt = 1'b1;
                end
                if (r_cnt == CNT_W'(3)) begin
                    w_state_nxt = S_FINISH;
                    w_match_nxt = ~(r_err | w_word_bad);
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = S_CHK_RD;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_din       <= '0;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_din_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_din       <= w_din_nxt;
            r_match     <= w_match_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FINISH);
            r_din_ready <= (w_state_nxt == S_PROG) || (w_state_nxt == S_CHK_RD);
        end
    end

`ifdef DIGILOCK_LOCKOUT_EN
    localparam int unsigned FAIL_W = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);
    localparam int unsigned LOCK_W = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);

    logic [FAIL_W-1:0] r_fails;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_locked;
    logic              r_chk_fin;

    assign locked   = r_locked;
    assign w_cmd_ok = ~r_locked;

    // Fail counter and lockout timer; r_chk_fin marks a FINISH that ends a check
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fails    <= '0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_chk_fin  <= 1'b0;
        end else begin
            r_chk_fin <= (r_state == S_CHK_CMP) && (w_state_nxt == S_FINISH);
            if (r_locked) begin
                if (r_lock_cnt == '0) begin
                    r_locked <= 1'b0;
                    r_fails  <= '0;
                end else begin
                    r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
                end
            end else if ((r_state == S_FINISH) && r_chk_fin) begin
                if (r_match) begin
                    r_fails <= '0;
                end else begin
                    r_fails <= r_fails + FAIL_W'(1);
                    if ((32'(r_fails) + 32'd1) >= MAX_FAILS) begin
                        r_locked   <= 1'b1;
                        r_lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
                    end
                end
            end
        end
    end
`else
    assign locked   = 1'b0;
    assign w_cmd_ok = 1'b1;
`endif

endmodule
